glove_tracker: RTL and testbench

//  Upstream of the ball state machine; one instance per glove.

---
 rtl/gloves_defs.sv | 20 ++
 rtl/glove_avg.sv | 52 +++++
 rtl/glove_tracker.sv | 162 ++++++++++++++++
 tb/tb_glove_tracker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gloves_defs.sv
// Shared definitions for the glove tracking path: state encodings, coordinate
// width, camera geometry and default pixel-to-millimetre scale factors.
package gloves_defs;

    typedef enum logic {
        ST_LOST  = 1'b0,
        ST_TRACK = 1'b1
    } glove_state_t;

    localparam int COORD_W         = 16;
    localparam int FRAME_W         = 1280;
    localparam int FRAME_H         = 768;
    localparam int DEF_MM_PER_PX_X = 8;
    localparam int DEF_MM_PER_PX_Y = 8;

    function automatic logic [COORD_W-1:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/glove_avg.sv
// Running average over the last 2^AVG_LOG2 pushed samples; prime fills every
// entry with one value so the average jumps straight to it.
module glove_avg
    import gloves_defs::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               prime,
    input  logic [COORD_W-1:0] din,
    output logic [COORD_W-1:0] dout
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = COORD_W + AVG_LOG2;

    logic [COORD_W-1:0]  mem_q [DEPTH];
    logic [COORD_W-1:0]  mem_d [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]    sum_q, sum_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        sum_d    = sum_q;
        if (prime) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = din;
            sum_d    = SUM_W'(din) << AVG_LOG2;
            wr_ptr_d = '0;
        end else if (push) begin
            mem_d[wr_ptr_q] = din;
            sum_d    = sum_q + SUM_W'(din) - SUM_W'(mem_q[wr_ptr_q]);
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            sum_q    <= sum_d;
        end
    end

    assign dout = COORD_W'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/glove_tracker.sv
// Per-glove tracker: scales camera centroids to mm, averages them, debounces the
// pinch flag and gates catching with a post-release cooldown. 3-stage pipeline.
module glove_tracker
    import gloves_defs::*;
#(
    parameter int MM_PER_PX_X = DEF_MM_PER_PX_X,
    parameter int MM_PER_PX_Y = DEF_MM_PER_PX_Y,
    parameter int AVG_LOG2    = 2,
    parameter int DEBOUNCE    = 3,
    parameter int COOLDOWN    = 64,
    parameter int MISS_LIMIT  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic               sample_found,
    input  logic [10:0]        sample_x,
    input  logic [9:0]         sample_y,
    input  logic               sample_closed,
    output logic [COORD_W-1:0] glove_x,
    output logic [COORD_W-1:0] glove_y,
    output logic               glove_closed,
    output logic               can_catch,
    output logic               tracking,
    output logic               out_valid
);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int CW = $clog2(COOLDOWN + 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    logic [1:0] rs_q, rs_d;
    logic       rst_n;
    assign rs_d  = {rs_q[0], 1'b1};
    assign rst_n = rs_q[1];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rs_q <= 2'b00;
        else        rs_q <= rs_d;
    end

    // S1: scale to mm
    logic               v1_q, f1_q, c1_q;
    logic               v1_d, f1_d, c1_d;
    logic [COORD_W-1:0] x1_q, y1_q, x1_d, y1_d;

    always_comb begin
        v1_d = sample_valid;
        f1_d = f1_q;
        c1_d = c1_q;
        x1_d = x1_q;
        y1_d = y1_q;
        if (sample_valid) begin
            f1_d = sample_found;
            c1_d = sample_closed;
            x1_d = sat16(32'(sample_x) * 32'(MM_PER_PX_X));
            if (32'(sample_y) >= 32'(FRAME_H))
                y1_d = '0;
            else
                y1_d = sat16((32'(FRAME_H - 1) - 32'(sample_y)) * 32'(MM_PER_PX_Y));
        end
    end

    // S2: averaging, FSM, debounce, cooldown
    glove_state_t   state_q, state_d;
    logic [MW-1:0]  miss_q, miss_d;
    logic [DW-1:0]  db_q, db_d;
    logic [CW-1:0]  cool_q, cool_d;
    logic           closed_q, closed_d;
    logic           upd_q, upd_d;
    logic           push, prime;
    logic [COORD_W-1:0] avg_x, avg_y;

    assign prime = v1_q && f1_q && (state_q == ST_LOST);
    assign push  = v1_q && f1_q && (state_q == ST_TRACK);
    assign upd_d = v1_q && f1_q;

    glove_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
        .clk(clk), .reset(rst_n), .push(push), .prime(prime), .din(x1_q), .dout(avg_x)
    );
    glove_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
        .clk(clk), .reset(rst_n), .push(push), .prime(prime), .din(y1_q), .dout(avg_y)
    );

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        db_d     = db_q;
        cool_d   = cool_q;
        closed_d = closed_q;
        if (v1_q) begin
            if (cool_q != '0) cool_d = cool_q - 1'b1;
            if (state_q == ST_LOST) begin
                if (f1_q) begin
                    state_d = ST_TRACK;
                    miss_d  = '0;
                    db_d    = '0;
                end
            end else if (!f1_q) begin
                if (miss_q == MISS_LAST) begin
                    state_d  = ST_LOST;
                    miss_d   = '0;
                    db_d     = '0;
                    closed_d = 1'b0;
                    if (closed_q) cool_d = COOL_LOAD;
                end else begin
                    miss_d = miss_q + 1'b1;
                end
            end else begin
                miss_d = '0;
                if (c1_q != closed_q) begin
                    if (db_q == DB_LAST) begin
                        closed_d = ~closed_q;
                        db_d     = '0;
                        if (closed_q) cool_d = COOL_LOAD;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    db_d = '0;
                end
            end
        end
    end

    // S3: registered outputs
    logic [COORD_W-1:0] gx_q, gx_d, gy_q, gy_d;
    logic               gc_q, gc_d, cc_q, cc_d, trk_q, trk_d, ov_q, ov_d;

    always_comb begin
        gx_d  = upd_q ? avg_x : gx_q;
        gy_d  = upd_q ? avg_y : gy_q;
        ov_d  = upd_q;
        gc_d  = closed_q;
        trk_d = (state_q == ST_TRACK);
        cc_d  = (state_q == ST_TRACK) && (cool_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; f1_q <= 1'b0; c1_q <= 1'b0; x1_q <= '0; y1_q <= '0;
            state_q <= ST_LOST; miss_q <= '0; db_q <= '0; cool_q <= '0;
            closed_q <= 1'b0; upd_q <= 1'b0;
            gx_q <= '0; gy_q <= '0; gc_q <= 1'b0; cc_q <= 1'b0; trk_q <= 1'b0; ov_q <= 1'b0;
        end else begin
            v1_q <= v1_d; f1_q <= f1_d; c1_q <= c1_d; x1_q <= x1_d; y1_q <= y1_d;
            state_q <= state_d; miss_q <= miss_d; db_q <= db_d; cool_q <= cool_d;
            closed_q <= closed_d; upd_q <= upd_d;
            gx_q <= gx_d; gy_q <= gy_d; gc_q <= gc_d; cc_q <= cc_d; trk_q <= trk_d; ov_q <= ov_d;
        end
    end

    assign glove_x      = gx_q;
    assign glove_y      = gy_q;
    assign glove_closed = gc_q;
    assign can_catch    = cc_q;
    assign tracking     = trk_q;
    assign out_valid    = ov_q;

endmodule

// File: tb/tb_glove_tracker.sv
// Directed bench for glove_tracker: a sample-level behavioural model predicts every
// output cycle, and literal expectations pin the model at key points.
module tb_glove_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid, sample_found, sample_closed;
    logic [10:0] sample_x;
    logic [9:0]  sample_y;
    logic [15:0] glove_x, glove_y;
    logic        glove_closed, can_catch, tracking, out_valid;

    glove_tracker dut (
        .clk(clk), .reset(reset),
        .sample_valid(sample_valid), .sample_found(sample_found),
        .sample_x(sample_x), .sample_y(sample_y), .sample_closed(sample_closed),
        .glove_x(glove_x), .glove_y(glove_y), .glove_closed(glove_closed),
        .can_catch(can_catch), .tracking(tracking), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {int due; bit ov; int gx; int gy; bit trk; bit cl; bit can;} rec_t;
    typedef struct {int due; string nm; int kind; int val;} lit_t;
    rec_t mq[$];
    lit_t lq[$];

    // model state, one step per camera sample
    bit m_trk, m_cl;
    int m_miss, m_db, m_cool, m_gx, m_gy;
    int hx[$], hy[$];
    int last_due;

    bit exp_ov, exp_trk, exp_cl, exp_can;
    int exp_gx, exp_gy;

    task automatic cmp(string nm, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        m_trk = 0; m_cl = 0; m_miss = 0; m_db = 0; m_cool = 0; m_gx = 0; m_gy = 0;
        hx.delete(); hy.delete(); mq.delete(); lq.delete();
        exp_ov = 0; exp_trk = 0; exp_cl = 0; exp_can = 0; exp_gx = 0; exp_gy = 0;
    endtask

    function automatic int avg4(int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s / 4;
    endfunction

    task automatic model_step(bit f, int x, int y, bit c, output rec_t r);
        int xm, ym;
        xm = (x * 8 > 65535) ? 65535 : x * 8;
        ym = (y >= 768) ? 0 : (((767 - y) * 8 > 65535) ? 65535 : (767 - y) * 8);
        if (m_cool > 0) m_cool--;
        r.ov = 0;
        if (!m_trk) begin
            if (f) begin
                m_trk = 1; m_miss = 0; m_db = 0;
                hx.delete(); hy.delete();
                repeat (4) begin hx.push_back(xm); hy.push_back(ym); end
                r.ov = 1;
            end
        end else if (!f) begin
            m_miss++;
            if (m_miss == 8) begin
                m_trk = 0; m_miss = 0; m_db = 0;
                if (m_cl) m_cool = 64;
                m_cl = 0;
            end
        end else begin
            m_miss = 0;
            void'(hx.pop_front()); hx.push_back(xm);
            void'(hy.pop_front()); hy.push_back(ym);
            r.ov = 1;
            if (c != m_cl) begin
                m_db++;
                if (m_db == 3) begin
                    if (m_cl) m_cool = 64;
                    m_cl = !m_cl;
                    m_db = 0;
                end
            end else m_db = 0;
        end
        if (r.ov) begin m_gx = avg4(hx); m_gy = avg4(hy); end
        r.gx = m_gx; r.gy = m_gy; r.trk = m_trk; r.cl = m_cl;
        r.can = m_trk && (m_cool == 0);
    endtask

    task automatic send(bit f, int x, int y, bit c);
        rec_t r;
        @(posedge clk); #1;
        sample_valid = 1; sample_found = f; sample_x = 11'(x); sample_y = 10'(y); sample_closed = c;
        model_step(f, x, y, c, r);
        r.due = cyc + 3;
        last_due = r.due;
        mq.push_back(r);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            sample_valid = 0; sample_found = 0; sample_closed = 0;
        end
    endtask

    task automatic lit(string nm, int kind, int val);
        lit_t l;
        l.due = last_due; l.nm = nm; l.kind = kind; l.val = val;
        lq.push_back(l);
    endtask

    always @(negedge clk) begin
        rec_t r;
        lit_t l;
        int act;
        exp_ov = 0;
        while (mq.size() > 0 && mq[0].due == cyc) begin
            r = mq.pop_front();
            exp_ov = r.ov; exp_gx = r.gx; exp_gy = r.gy;
            exp_trk = r.trk; exp_cl = r.cl; exp_can = r.can;
        end
        cmp("out_valid", int'(out_valid), int'(exp_ov));
        cmp("glove_x", int'(glove_x), exp_gx);
        cmp("glove_y", int'(glove_y), exp_gy);
        cmp("glove_closed", int'(glove_closed), int'(exp_cl));
        cmp("can_catch", int'(can_catch), int'(exp_can));
        cmp("tracking", int'(tracking), int'(exp_trk));
        while (lq.size() > 0 && lq[0].due == cyc) begin
            l = lq.pop_front();
            case (l.kind)
                0: act = int'(glove_x);
                1: act = int'(glove_y);
                2: act = int'(glove_closed);
                3: act = int'(can_catch);
                default: act = int'(tracking);
            endcase
            cmp(l.nm, act, l.val);
        end
    end

    task automatic check_zero_now();
        cmp("rst_glove_x", int'(glove_x), 0);
        cmp("rst_glove_y", int'(glove_y), 0);
        cmp("rst_closed", int'(glove_closed), 0);
        cmp("rst_can_catch", int'(can_catch), 0);
        cmp("rst_tracking", int'(tracking), 0);
        cmp("rst_out_valid", int'(out_valid), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        model_clear();
        #1 check_zero_now();
        repeat (3) @(posedge clk);
        #1 reset = 1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; sample_valid = 0; sample_found = 0; sample_closed = 0;
        sample_x = '0; sample_y = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1;
        repeat (4) @(posedge clk);

        // 1: first found sample primes the average
        send(1, 100, 767, 0);
        lit("t1_gx", 0, 800); lit("t1_gy", 1, 0); lit("t1_trk", 4, 1); lit("t1_can", 3, 1);
        idle(4);

        // 2: running average of x after priming
        send(1, 100, 767, 0); lit("t2_gx0", 0, 800);
        send(1, 104, 767, 0); lit("t2_gx1", 0, 808);
        send(1, 108, 767, 0); lit("t2_gx2", 0, 824);
        send(1, 112, 767, 0); lit("t2_gx3", 0, 848);
        idle(3);

        // 3: two closed samples are not enough; three are
        send(1, 100, 767, 1);
        send(1, 100, 767, 1);
        send(1, 100, 767, 0); lit("t3_open", 2, 0);
        send(1, 100, 767, 1);
        send(1, 100, 767, 1); lit("t3_2nd", 2, 0);
        send(1, 100, 767, 1); lit("t3_closed", 2, 1);
        idle(3);

        // 4: release then cooldown of 64 strobes
        send(1, 100, 767, 0);
        send(1, 100, 767, 0); lit("t4_still", 2, 1);
        send(1, 100, 767, 0); lit("t4_rel", 2, 0); lit("t4_can0", 3, 0);
        for (int i = 1; i <= 64; i++) begin
            send(1, 100, 800, 0);
            if (i == 63) lit("t4_can63", 3, 0);
            if (i == 64) lit("t4_can64", 3, 1);
        end
        idle(3);

        // 5: closed, then 8 misses drop tracking
        send(1, 120, 700, 1);
        send(1, 120, 700, 1);
        send(1, 120, 700, 1); lit("t5_closed", 2, 1);
        for (int i = 1; i <= 8; i++) begin
            send(0, 0, 0, 1);
            if (i == 7) lit("t5_trk7", 4, 1);
            if (i == 8) begin
                lit("t5_trk8", 4, 0); lit("t5_cl8", 2, 0); lit("t5_can8", 3, 0);
                lit("t5_gx_hold", 0, 920); lit("t5_gy_hold", 1, 402);
            end
        end
        idle(3);

        // 6: reset with a sample in S2 discards it
        send(1, 50, 10, 0);
        idle(1);
        do_reset();
        idle(8);
        send(1, 1, 767, 0); lit("t6_gx", 0, 8); lit("t6_trk", 4, 1);
        idle(8);

        if (lq.size() != 0 || mq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pending: %0d literal and %0d model entries never reached", lq.size(), mq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
